memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  MEM stage of the 5-stage RISC-V pipeline. Consumes the EX_MEM_* bundle from execution.
//  - Issues loads/stores to data memory over a valid/ready + rdata_valid handshake.
//  - Aligns store data and strobes; sign/zero-extends load data.
//  - Stalls the upstream pipeline while memory is busy, then registers the MEM_WB_* bundle.
// PARAMETERS
//  TIMEOUT_CYCLES  255  wait-cycle limit before abort (only with MEM_TIMEOUT_EN); 8-bit counter
// PORTS
//  clk                  in   1   single clock; one clock; reset is asynchronous and active-low
//  rst_n                in   1   asynchronous active-low reset
//  EX_MEM_PC            in   32  PC of the instruction in MEM
//  EX_MEM_Instr         in   32  instruction; funct3 = [14:12]
//  EX_MEM_rd            in   5   destination register
//  EX_MEM_ALU_Result    in   32  effective address / ALU value
//  EX_MEM_rdata2        in   32  store data (already forwarded)
//  EX_MEM_MemRead       in   1   load
//  EX_MEM_MemWrite      in   1   store
//  EX_MEM_Mem2Reg       in   2   WB source select, passed through
//  EX_MEM_RegWrite      in   1   register write enable
//  mem_req_valid        out  1   memory request valid
//  mem_req_ready        in   1   memory accepts request
//  Address              out  32  word address: {ALU_Result[31:2], 2'b00}
//  MemWrite / MemRead   out  1   request type
//  Write_data           out  32  lane-replicated store data
//  Write_strb           out  4   byte enables
//  Read_data            in   32  load data
//  Read_data_valid      in   1   load data valid
//  mem_stall            out  1   hold PC/IF_ID/ID_EX/EX_MEM this cycle
//  mem_err              out  1   one-cycle pulse on misaligned access or timeout
//  MEM_WB_PC / MEM_WB_Instr / MEM_WB_rd / MEM_WB_Mem2Reg / MEM_WB_ALU_Result  out  registered copies
//  MEM_WB_RegWrite      out  1   registered write enable; 0 for bubbles
//  MEM_WB_load_data     out  32  registered extended load data
// BEHAVIOUR
//  Reset: all MEM_WB_* = 0, state = IDLE, counter = 0, mem_err = 0.
//   - mem_req_valid, mem_stall, MemRead and MemWrite are forced 0 while rst_n is low.
//   - Reset mid-transaction abandons the request; no MEM_WB update.
//  op = MemRead | MemWrite. Misaligned access (LH/LHU/SH with addr[0]; LW/SW with addr[1:0] != 0):
//   - no request issued; MEM_WB_RegWrite <= 0; mem_err pulses the next cycle; no stall.
//  FSM {IDLE, REQ, WAIT_RD}; request valid combinationally in IDLE (aligned op) and in REQ.
//  - IDLE, no op: MEM_WB <= EX_MEM bundle, 0 wait cycles.
//  - IDLE/REQ, store with ready: strobes/data written; MEM_WB updated; next state IDLE; stall = 0.
//  - IDLE, op without ready: go to REQ; stall = 1.
//  - IDLE/REQ, load with ready: go to WAIT_RD; stall = 1.
//  - WAIT_RD with Read_data_valid (ready ignored): capture data; MEM_WB updated; go to IDLE; stall = 0.
//   Read_data_valid is accepted in the same cycle ready is seen only when already in WAIT_RD.
//  Any stall cycle: MEM_WB_RegWrite <= 0 (bubble); other MEM_WB_* hold. Inputs must hold while stall = 1.
//  Store lanes: SB strb = 1 << addr[1:0], data = {4{rdata2[7:0]}};
//   SH strb = addr[1] ? 1100 : 0011, data = {2{rdata2[15:0]}}; SW strb = 1111.
//  Load extract (byte/half chosen by addr[1:0]): funct3 000 LB sext8, 100 LBU zext8,
//   001 LH sext16, 101 LHU zext16, 010 LW. Other funct3 values load as LW.
//  Fixed latency: non-memory ops 1 cycle; store 1 + ready-wait cycles; load 1 + ready-wait + rvalid-wait cycles.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//   - Counter increments each REQ/WAIT_RD cycle and clears on leaving those states.
//   - When it reaches TIMEOUT_CYCLES: drop request; go to IDLE; mem_err pulses; stall released.
//   - The aborted instruction retires with MEM_WB_RegWrite = 0.
//  MEM_TIMEOUT_EN undefined: no counter; waits indefinitely; mem_err only for misalignment.
// TESTING
//  1. ADD (no op), RegWrite = 1, ALU = 0x55 -> next cycle MEM_WB_ALU_Result = 0x55, RegWrite = 1, stall never high.
//  2. SB addr 0x103, rdata2 = 0xAB, ready = 1 -> Write_strb = 1000, Write_data = 0xABABABAB, Address = 0x100, no stall.
//  3. LB addr 0x101, ready after 2 cycles, rvalid 1 cycle later, Read_data = 0x0000_8000 ->
//     stall = 1 for 4 cycles; MEM_WB_load_data = 0xFFFFFF80; bubbles carry RegWrite = 0.
//  4. LHU 0x102 with Read_data = 0xBEEF0000 -> 0x0000BEEF; LW at 0x106 -> no request, mem_err pulse, RegWrite = 0.
//  5. Drop rst_n while in WAIT_RD -> all outputs 0 immediately; after release, IDLE with no stray request.
//  6. (MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4) ready held 0 -> abort after 4 wait cycles; mem_err = 1 for 1 cycle; stall released.

Source files
------------

// File: rtl/memory_access.sv
// memory_access: MEM stage of the 5-stage RISC-V pipeline. Issues loads/stores, aligns/extends data,
// stalls upstream while memory is busy, registers MEM_WB_*. Optional abort-on-timeout: MEM_TIMEOUT_EN.
module memory_access
`ifdef MEM_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] EX_MEM_PC,
  input  logic [31:0] EX_MEM_Instr,
  input  logic [4:0]  EX_MEM_rd,
  input  logic [31:0] EX_MEM_ALU_Result,
  input  logic [31:0] EX_MEM_rdata2,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [1:0]  EX_MEM_Mem2Reg,
  input  logic        EX_MEM_RegWrite,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] Address,
  output logic        MemWrite,
  output logic        MemRead,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic [31:0] Read_data,
  input  logic        Read_data_valid,
  output logic        mem_stall,
  output logic        mem_err,
  output logic [31:0] MEM_WB_PC,
  output logic [31:0] MEM_WB_Instr,
  output logic [4:0]  MEM_WB_rd,
  output logic [1:0]  MEM_WB_Mem2Reg,
  output logic [31:0] MEM_WB_ALU_Result,
  output logic        MEM_WB_RegWrite,
  output logic [31:0] MEM_WB_load_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RD = 2'd2} state_t;
  state_t state;

  logic [2:0]  funct3;
  logic [1:0]  lane;
  logic        op, is_load, is_byte, is_half, misaligned, aligned_op;
  logic        abort, req_raw, accept, store_done, load_done, stall_raw, retire_rw;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  assign funct3     = EX_MEM_Instr[14:12];
  assign lane       = EX_MEM_ALU_Result[1:0];
  assign op         = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign is_load    = EX_MEM_MemRead;
  assign is_byte    = (funct3[1:0] == 2'b00);
  assign is_half    = (funct3[1:0] == 2'b01);
  assign misaligned = op && ((is_half && lane[0]) || (!is_byte && !is_half && lane != 2'b00));
  assign aligned_op = op && !misaligned;

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt;
  assign abort = (state != IDLE) && (wait_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign abort = 1'b0;
`endif

  // Handshake: a request transfers on a cycle where mem_req_valid && mem_req_ready; valid never
  // depends on ready. Load data is taken only in WAIT_RD on Read_data_valid, ready ignored there.
  assign req_raw    = ((state == IDLE) && aligned_op) || ((state == REQ) && !abort);
  assign accept     = req_raw && mem_req_ready;
  assign store_done = accept && !is_load;
  assign load_done  = (state == WAIT_RD) && Read_data_valid && !abort;

  always_comb begin
    stall_raw = 1'b0;
    case (state)
      IDLE:    stall_raw = aligned_op && !store_done;
      REQ:     stall_raw = !store_done && !abort;
      WAIT_RD: stall_raw = !load_done && !abort;
      default: stall_raw = 1'b0;
    endcase
  end

  // Misaligned and aborted instructions still leave the stage, but never write the register file.
  assign retire_rw = EX_MEM_RegWrite && !misaligned && !abort;

  assign mem_req_valid = rst_n && req_raw;
  assign MemRead       = rst_n && req_raw && is_load;
  assign MemWrite      = rst_n && req_raw && !is_load;
  assign mem_stall     = rst_n && stall_raw;
  assign Address       = {EX_MEM_ALU_Result[31:2], 2'b00};
  assign dbg_state     = state;

  always_comb begin
    Write_strb = 4'b1111;
    Write_data = EX_MEM_rdata2;
    if (is_byte) begin
      Write_strb = 4'b0001 << lane;
      Write_data = {4{EX_MEM_rdata2[7:0]}};
    end else if (is_half) begin
      Write_strb = lane[1] ? 4'b1100 : 4'b0011;
      Write_data = {2{EX_MEM_rdata2[15:0]}};
    end
  end

  always_comb begin
    ld_byte = Read_data[7:0];
    case (lane)
      2'd1:    ld_byte = Read_data[15:8];
      2'd2:    ld_byte = Read_data[23:16];
      2'd3:    ld_byte = Read_data[31:24];
      default: ld_byte = Read_data[7:0];
    endcase
    ld_half = lane[1] ? Read_data[31:16] : Read_data[15:0];
    ld_ext  = Read_data;
    case (funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = Read_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      mem_err           <= 1'b0;
      MEM_WB_PC         <= '0;
      MEM_WB_Instr      <= '0;
      MEM_WB_rd         <= '0;
      MEM_WB_Mem2Reg    <= '0;
      MEM_WB_ALU_Result <= '0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_load_data  <= '0;
    end else begin
      mem_err <= ((state == IDLE) && misaligned) || abort;
      case (state)
        IDLE:    if (aligned_op && !store_done) state <= accept ? WAIT_RD : REQ;
        REQ:     if (abort || store_done) state <= IDLE;
                 else if (accept) state <= WAIT_RD;
        WAIT_RD: if (abort || load_done) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (stall_raw) begin
        MEM_WB_RegWrite <= 1'b0;
      end else begin
        MEM_WB_PC         <= EX_MEM_PC;
        MEM_WB_Instr      <= EX_MEM_Instr;
        MEM_WB_rd         <= EX_MEM_rd;
        MEM_WB_Mem2Reg    <= EX_MEM_Mem2Reg;
        MEM_WB_ALU_Result <= EX_MEM_ALU_Result;
        MEM_WB_RegWrite   <= retire_rw;
        if (load_done) MEM_WB_load_data <= ld_ext;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Counts every cycle spent stalled in REQ/WAIT_RD; any exit to IDLE clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_cnt <= '0;
    else if ((state != IDLE) && stall_raw) wait_cnt <= wait_cnt + 8'd1;
    else wait_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed and random instructions, scoreboard queues checked by monitors.
module tb_memory_access;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] EX_MEM_PC = '0, EX_MEM_Instr = '0, EX_MEM_ALU_Result = '0, EX_MEM_rdata2 = '0;
  logic [4:0]  EX_MEM_rd = '0;
  logic        EX_MEM_MemRead = 1'b0, EX_MEM_MemWrite = 1'b0, EX_MEM_RegWrite = 1'b0;
  logic [1:0]  EX_MEM_Mem2Reg = '0;
  logic        mem_req_valid, mem_req_ready = 1'b0, MemWrite, MemRead;
  logic [31:0] Address, Write_data, Read_data = '0;
  logic [3:0]  Write_strb;
  logic        Read_data_valid = 1'b0, mem_stall, mem_err;
  logic [31:0] MEM_WB_PC, MEM_WB_Instr, MEM_WB_ALU_Result, MEM_WB_load_data;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  MEM_WB_Mem2Reg, dbg_state;
  logic        MEM_WB_RegWrite;

`ifdef MEM_TIMEOUT_EN
  memory_access #(.TIMEOUT_CYCLES(TO)) dut (
`else
  memory_access dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .EX_MEM_PC(EX_MEM_PC), .EX_MEM_Instr(EX_MEM_Instr), .EX_MEM_rd(EX_MEM_rd),
    .EX_MEM_ALU_Result(EX_MEM_ALU_Result), .EX_MEM_rdata2(EX_MEM_rdata2),
    .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
    .EX_MEM_Mem2Reg(EX_MEM_Mem2Reg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .Address(Address),
    .MemWrite(MemWrite), .MemRead(MemRead), .Write_data(Write_data), .Write_strb(Write_strb),
    .Read_data(Read_data), .Read_data_valid(Read_data_valid), .mem_stall(mem_stall),
    .mem_err(mem_err), .MEM_WB_PC(MEM_WB_PC), .MEM_WB_Instr(MEM_WB_Instr), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_Mem2Reg(MEM_WB_Mem2Reg), .MEM_WB_ALU_Result(MEM_WB_ALU_Result),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_load_data(MEM_WB_load_data), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [31:0] pc, instr, alu, ld;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    logic        rw, err;
    logic [7:0]  stalls;
  } ret_t;
  typedef struct packed {
    logic [31:0] addr, data;
    logic [3:0]  strb;
    logic        rd, wr;
  } req_t;

  ret_t exp_q[$];
  req_t req_q[$];
  int n_cmp = 0, n_err = 0;
  logic mon_en = 1'b0;
  logic [31:0] last_load = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference for load extension: select the byte/half by byte offset, then extend.
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [31:0] v;
    int off;
    off = int'(a % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (d >> (8 * off)) & 32'hFF;
        if (f3 == 3'd0 && v[7]) v = v | 32'hFFFF_FF00;
      end
      3'd1, 3'd5: begin
        v = (d >> (8 * off)) & 32'hFFFF;
        if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; holds the instruction for its whole expected stay in MEM.
  // d: cycles before ready; r: extra WAIT_RD cycles before rvalid; to: expect a timeout abort.
  task automatic issue(input logic [2:0] f3, input logic rd_en, input logic wr_en,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       input int d, input int r, input logic rw, input logic to);
    ret_t it;
    req_t rq;
    int size, stalls;
    logic op, mis, accepted;
    logic [31:0] instr;
    instr = $urandom();
    instr[14:12] = f3;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    op = rd_en | wr_en;
    mis = op && ((addr % 32'(size)) != 0);
    if (!op || mis) stalls = 0;
    else if (to) stalls = TO + 1;
    else if (wr_en) stalls = d;
    else stalls = d + 1 + r;
    accepted = op && !mis && (to ? (d < stalls) : 1'b1);
    it.pc = $urandom();
    it.instr = instr;
    it.alu = addr;
    it.rd = 5'($urandom_range(0, 31));
    it.m2r = 2'($urandom_range(0, 3));
    it.rw = rw && !mis && !to;
    it.err = mis || to;
    it.stalls = 8'(stalls);
    if (rd_en && !mis && !to) last_load = load_model(f3, addr, rdata);
    it.ld = last_load;
    exp_q.push_back(it);
    if (accepted) begin
      rq.addr = addr & ~32'd3;
      rq.rd = rd_en;
      rq.wr = !rd_en;
      case (size)
        1: begin rq.strb = 4'b0001 << addr[1:0]; rq.data = {24'd0, wdata[7:0]} * 32'h0101_0101; end
        2: begin rq.strb = 4'b0011 << addr[1:0]; rq.data = {16'd0, wdata[15:0]} * 32'h0001_0001; end
        default: begin rq.strb = 4'hF; rq.data = wdata; end
      endcase
      req_q.push_back(rq);
    end
    EX_MEM_PC = it.pc; EX_MEM_Instr = instr; EX_MEM_rd = it.rd; EX_MEM_ALU_Result = addr;
    EX_MEM_rdata2 = wdata; EX_MEM_MemRead = rd_en; EX_MEM_MemWrite = wr_en;
    EX_MEM_Mem2Reg = it.m2r; EX_MEM_RegWrite = rw;
    for (int k = 0; k <= stalls; k++) begin
      if (op && !mis) begin
        if (k < d) mem_req_ready = 1'b0;
        else if (k == d) mem_req_ready = 1'b1;
        else mem_req_ready = 1'($urandom_range(0, 1));
        Read_data_valid = rd_en && (k == d + 1 + r);
        if (rd_en && k == d) Read_data_valid = 1'($urandom_range(0, 1));
        Read_data = (rd_en && k == d + 1 + r) ? rdata : $urandom();
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
        Read_data_valid = 1'($urandom_range(0, 1));
        Read_data = $urandom();
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic idle_inputs();
    EX_MEM_PC = '0; EX_MEM_Instr = '0; EX_MEM_rd = '0; EX_MEM_ALU_Result = '0; EX_MEM_rdata2 = '0;
    EX_MEM_MemRead = 1'b0; EX_MEM_MemWrite = 1'b0; EX_MEM_Mem2Reg = '0; EX_MEM_RegWrite = 1'b0;
    mem_req_ready = 1'b0; Read_data_valid = 1'b0;
  endtask

  task automatic end_phase();
    idle_inputs();
    @(negedge clk); #1;
    mon_en = 1'b0;
    chk("ret_q_empty", 32'(exp_q.size()), 32'd0);
    chk("req_q_empty", 32'(req_q.size()), 32'd0);
  endtask

  task automatic rand_ops(input int n);
    logic [2:0] f3;
    logic [31:0] addr;
    int kind;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      f3 = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      addr = $urandom();
      if ($urandom_range(0, 2) != 0 && f3[1:0] != 2'b00)
        addr[1:0] = (f3[1:0] == 2'b01) ? (addr[1:0] & 2'b10) : 2'b00;
      issue(f3, kind == 1 || kind == 3, kind == 2, addr, $urandom(), $urandom(),
            $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  // ---------------- monitors ----------------
  logic prev_live = 1'b0, prev_retire = 1'b0;
  int stall_cnt = 0, retire_stalls = 0;

  always @(negedge clk) begin
    ret_t e;
    req_t q;
    if (!rst_n || !mon_en) begin
      prev_live = 1'b0; prev_retire = 1'b0; stall_cnt = 0;
    end else begin
      if (prev_live) begin
        if (prev_retire) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL retire_unexpected: got a retire, expected none at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("wb_pc", MEM_WB_PC, e.pc);
            chk("wb_instr", MEM_WB_Instr, e.instr);
            chk("wb_rd", 32'(MEM_WB_rd), 32'(e.rd));
            chk("wb_m2r", 32'(MEM_WB_Mem2Reg), 32'(e.m2r));
            chk("wb_alu", MEM_WB_ALU_Result, e.alu);
            chk("wb_regwrite", 32'(MEM_WB_RegWrite), 32'(e.rw));
            chk("wb_load_data", MEM_WB_load_data, e.ld);
            chk("mem_err", 32'(mem_err), 32'(e.err));
            chk("stall_cycles", 32'(retire_stalls), 32'(e.stalls));
          end
        end else begin
          chk("bubble_regwrite", 32'(MEM_WB_RegWrite), 32'd0);
          chk("mem_err_idle", 32'(mem_err), 32'd0);
        end
      end
      prev_live = 1'b1;
      if (mem_stall) begin
        stall_cnt++; prev_retire = 1'b0;
      end else begin
        retire_stalls = stall_cnt; stall_cnt = 0; prev_retire = 1'b1;
      end
      if (mem_req_valid && mem_req_ready) begin
        if (req_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL req_unexpected: got request to %h, expected none at %0t", Address, $time);
        end else begin
          q = req_q.pop_front();
          chk("req_addr", Address, q.addr);
          chk("req_read", 32'(MemRead), 32'(q.rd));
          chk("req_write", 32'(MemWrite), 32'(q.wr));
          if (q.wr) begin
            chk("req_strb", 32'(Write_strb), 32'(q.strb));
            chk("req_data", Write_data, q.data);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic check_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, "_memread"}, 32'(MemRead), 32'd0);
    chk({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
    chk({tag, "_err"}, 32'(mem_err), 32'd0);
    chk({tag, "_wb_rw"}, 32'(MEM_WB_RegWrite), 32'd0);
    chk({tag, "_wb_pc"}, MEM_WB_PC, 32'd0);
    chk({tag, "_wb_alu"}, MEM_WB_ALU_Result, 32'd0);
    chk({tag, "_wb_ld"}, MEM_WB_load_data, 32'd0);
  endtask

  initial begin
    EX_MEM_MemRead = 1'b1; EX_MEM_ALU_Result = 32'h40; EX_MEM_Instr = 32'h0000_2000;
    mem_req_ready = 1'b1;
    #2 rst_n = 1'b0;
    #10 check_all_zero("reset");
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(3'b000, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);          // ADD
    issue(3'b000, 1'b0, 1'b1, 32'h103, 32'hAB, 32'h0, 0, 0, 1'b0, 1'b0);        // SB
    issue(3'b000, 1'b1, 1'b0, 32'h101, 32'h0, 32'h0000_8000, 2, 1, 1'b1, 1'b0); // LB
    issue(3'b101, 1'b1, 1'b0, 32'h102, 32'h0, 32'hBEEF_0000, 0, 0, 1'b1, 1'b0); // LHU
    issue(3'b010, 1'b1, 1'b0, 32'h106, 32'h0, 32'h1234_5678, 0, 0, 1'b1, 1'b0); // LW misaligned
    issue(3'b001, 1'b0, 1'b1, 32'h202, 32'h1234, 32'h0, 1, 0, 1'b0, 1'b0);      // SH upper half
    issue(3'b001, 1'b0, 1'b1, 32'h201, 32'h1234, 32'h0, 0, 0, 1'b0, 1'b0);      // SH misaligned
    issue(3'b010, 1'b0, 1'b1, 32'h208, 32'hCAFE_F00D, 32'h0, 2, 0, 1'b0, 1'b0); // SW
    issue(3'b011, 1'b1, 1'b0, 32'h20C, 32'h0, 32'h8765_4321, 1, 1, 1'b1, 1'b0); // odd funct3 as LW
    rand_ops(150);
    end_phase();

    // Reset while a load waits for its data.
    EX_MEM_MemRead = 1'b1; EX_MEM_Instr = 32'h0000_2000; EX_MEM_ALU_Result = 32'h300;
    EX_MEM_RegWrite = 1'b1; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    chk("waitrd_stall", 32'(mem_stall), 32'd1);
    chk("waitrd_valid", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    Read_data_valid = 1'b1; Read_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_reset_valid", 32'(mem_req_valid), 32'd0);
      chk("post_reset_stall", 32'(mem_stall), 32'd0);
      #1 Read_data_valid = 1'b0;
    end
    chk("post_reset_ld", MEM_WB_load_data, 32'd0);
    last_load = '0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    rand_ops(100);
`ifdef MEM_TIMEOUT_EN
    issue(3'b010, 1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 0, 100, 1'b1, 1'b1);       // load, no rvalid
    issue(3'b010, 1'b0, 1'b1, 32'h404, 32'h1111_2222, 32'h0, 100, 0, 1'b0, 1'b1); // store, no ready
    issue(3'b000, 1'b0, 1'b0, 32'h77, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0);
    rand_ops(20);
`endif
    end_phase();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
